keypad_responder: RTL and testbench
===================================

# keypad_responder

Memory-mapped 4x4 keypad controller on the CPU data bus, the responder end of the CPU's address/data/write-enable interface. It scans the matrix, debounces it and queues key-press codes in a FIFO. The CPU reads queued codes and status through a small register window and pops entries with a write. Out-of-window accesses return zero, so the data output can be OR-combined with the memory read path.

## Interface
- `BASE_ADDR`, default 32'h0000_F000: word-aligned base of the 16-byte register window.
- `SCAN_DIV`, default 50000: clock cycles each column is driven (1 ms at 50 MHz). Minimum 2.
- `DEBOUNCE`, default 4: consecutive identical sweep snapshots required to accept a new key state. Minimum 1.
- `FIFO_DEPTH`, default 8: key-code FIFO entries. Must be a power of two, 2..16.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr_in`  in  32  byte address from CPU.
- `data_in`  in  32  write data from CPU.
- `wr_en`  in  1  CPU write strobe; may be held for several cycles.
- `data_out`  out  32  registered read data; 0 when the address is outside the window.
- `cols`  out  4  column drive, active-low, one-hot-low while scanning.
- `rows`  in  4  row sense, active-low, externally pulled up.

## Operation
- **Address decode:** hit when `addr_in[31:4] == BASE_ADDR[31:4]`. `addr_in[3:2]` selects the register; `addr_in[1:0]` is ignored.
  - 0x0 DATA: reads as {27'b0, valid, code[3:0]}, the FIFO head without popping. Writing any value pops the FIFO.
  - 0x4 STATUS: reads as {24'b0, count[4:0], overflow, full, empty}. Writing with bit0=1 clears `overflow`.
  - 0x8 CTRL: read/write; bit0 is scan_en. Other bits read 0.
  - 0xC: reads 0; writes are ignored.
- **Write strobe:** register writes act only on the rising edge of `wr_en & hit`, detected against `wr_en` registered the previous cycle. Holding `wr_en` for N cycles produces exactly one pop or clear.
- **Scanner:**
  - A divider counts 0..SCAN_DIV-1.
  - Column index c (0..3) is driven low; the others are driven high.
  - On the terminal divider count, `~rows` is latched into snapshot bits [c*4+3:c*4] and c advances.
  - After c=3 the 16-bit sweep snapshot is complete.
- **Debounce:**
  - At the end of each sweep the snapshot is compared with the previous one. If equal, the stable counter increments, saturating at DEBOUNCE. Otherwise it resets to 1.
  - When the counter reaches DEBOUNCE, `stable_keys` is updated to the snapshot.
  - Newly pressed keys are `stable_keys_new & ~stable_keys_old`. They go into a pending mask.
- **Push:** the lowest set bit of the pending mask is pushed, one per cycle, with code = c*4+r. Its pending bit is cleared. Releases are not queued.
- **FIFO:**
  - Push while full: data is dropped and `overflow` is set (sticky).
  - Pop while empty: no-op.
  - Push and pop in the same cycle when full: both take effect; count is unchanged and no overflow.
  - Push and pop in the same cycle when empty: the push is stored and the pop is a no-op.
  - Pointers wrap modulo FIFO_DEPTH.
- **scan_en=0:**
  - `cols` = 4'b1111.
  - Divider, column index and stable counter are held at 0.
  - Partial snapshot is discarded; the pending mask is cleared.
  - `stable_keys` and FIFO contents are retained.
  - Re-enabling starts a fresh sweep at column 0.

## Timing
- **Reset values:**
  - `data_out` = 0, `cols` = 4'b1110, scan_en = 1.
  - FIFO empty, overflow = 0.
  - Divider, column index, snapshot, stable counter, `stable_keys` and pending mask all 0.
- **Read latency:** `data_out` reflects the `addr_in` sampled at edge k, valid after edge k. A pop or push at edge k is visible in DATA/STATUS reads sampled at edge k+1.
- **Column period:** `cols` changes on the terminal-count edge, every SCAN_DIV cycles. A full sweep is 4*SCAN_DIV cycles.
- **Press-to-FIFO latency:** for a key held from the start of a sweep, the push occurs 1 cycle after the end of the DEBOUNCE-th identical sweep, plus 1 cycle per lower-indexed key pending ahead of it.
- **Reset mid-operation:** returns to reset values on the next edge; pending keys and FIFO contents are lost.

## Configuration
- `KEYPAD_IRQ_EN` defined:
  - Adds output port `irq` (1 bit, registered, reset 0).
  - `irq` = CTRL bit1 (irq_en, reset 0) & ~empty, updated each cycle.
  - CTRL bit1 becomes read/write.
- `KEYPAD_IRQ_EN` undefined: no `irq` port, and CTRL bit1 reads 0 with writes ignored.

## Test plan
- Test configuration: SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4.
- Reset, read 0xF004 → `data_out` = 32'h1 (empty). Read 0xF000 → 0. Read 0x0000_1000 → 0. `cols` = 4'b1110.
- Hold key (col 2, row 1) low for 3 sweeps → one push. Read DATA → 32'h19 (valid=1, code 9). Write DATA with `wr_en` held 5 cycles → STATUS = 32'h1.
- Bounce key 5 for alternating single sweeps, then hold it for 2 sweeps → exactly one entry, code 5. No entry during bouncing.
- Keys 3 and 12 pressed in the same sweep → FIFO holds 3 then 12 on consecutive cycles. STATUS count = 2.
- Fill 4 entries, press a 5th key → STATUS = {count 4, overflow, full} = 32'h26. Write 0xF004 with data 1 → 32'h22. Pop and push in the same cycle while full → count stays 4, overflow stays 0.
- Write CTRL = 0 mid-sweep → `cols` = 4'b1111 next cycle and no pushes. Write CTRL = 1 → `cols` = 4'b1110 and a fresh sweep starts. Assert `rst` with 3 entries queued → STATUS = 32'h1.

Source files
------------

// File: rtl/keypad_responder.sv
// keypad_responder: memory-mapped 4x4 keypad scanner, debouncer and key-code FIFO; define KEYPAD_IRQ_EN to add the irq output
module keypad_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        wr_en,
  output logic [31:0] data_out,
  output logic [3:0]  cols,
  input  logic [3:0]  rows
`ifdef KEYPAD_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE);
  localparam logic [4:0] FULL_CNT = 5'(FIFO_DEPTH);
  logic hit, wr_q, we, ctrl_we, scan_en, irq_en;
  logic tc, sweep_end, upd, push, pop, do_push, do_pop, clr_ovf, overflow, full, empty;
  logic [DW-1:0] div;
  logic [1:0] c;
  logic [11:0] snap;
  logic [15:0] sweep, prev_snap, stable_keys, pending, push_mask;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] code, head;
  logic [3:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [4:0] count;
  logic [31:0] rd;
  logic unused_ok;
  assign unused_ok = ^{data_in[31:1], addr_in[1:0]};
  always_comb begin
    hit = addr_in[31:4] == BASE_ADDR[31:4];
    we = wr_en & ~wr_q & hit;
    ctrl_we = we & (addr_in[3:2] == 2'd2);
    pop = we & (addr_in[3:2] == 2'd0);
    clr_ovf = we & (addr_in[3:2] == 2'd1) & data_in[0];
    tc = div == DIV_LAST;
    sweep_end = tc & (c == 2'd3);
    sweep = {~rows, snap};
    cnt_nx = sweep != prev_snap ? CW'(1) : cnt == DB ? DB : cnt + 1'b1;
    upd = scan_en & sweep_end & (cnt_nx == DB);
    push_mask = pending & (~pending + 16'd1);
    push = scan_en & (|pending);
    code = '0;
    for (int i = 15; i >= 0; i--) if (pending[i]) code = 4'(i);
    empty = count == 5'd0;
    full = count == FULL_CNT;
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    head = empty ? 4'd0 : mem[rptr];
    rd = ~hit ? 32'd0 :
         addr_in[3:2] == 2'd0 ? {27'b0, ~empty, head} :
         addr_in[3:2] == 2'd1 ? {24'b0, count, overflow, full, empty} :
         addr_in[3:2] == 2'd2 ? {30'b0, irq_en, scan_en} : 32'd0;
    cols = scan_en ? ~(4'b0001 << c) : 4'b1111;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= 1'b0;
      data_out <= '0;
      scan_en <= 1'b1;
    end else begin
      wr_q <= wr_en;
      data_out <= rd;
      if (ctrl_we) scan_en <= data_in[0];
    end
  end
`ifdef KEYPAD_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_we) irq_en <= data_in[1];
      irq <= irq_en & ~empty;
    end
  end
`else
  assign irq_en = 1'b0;
`endif
  // column snapshots shift in from the top so column 0 lands in bits [3:0]
  always_ff @(posedge clk) begin
    if (rst || !scan_en) begin
      div <= '0;
      c <= '0;
      snap <= '0;
      cnt <= '0;
      pending <= '0;
    end else begin
      div <= tc ? '0 : div + 1'b1;
      if (tc) begin
        c <= c + 1'b1;
        snap <= {~rows, snap[11:4]};
      end
      if (sweep_end) cnt <= cnt_nx;
      pending <= (pending & ~push_mask) | (upd ? sweep & ~stable_keys : 16'd0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snap <= '0;
      stable_keys <= '0;
    end else if (scan_en && sweep_end) begin
      prev_snap <= sweep;
      if (upd) stable_keys <= sweep;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= code;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + {4'b0, do_push} - {4'b0, do_pop};
      overflow <= (overflow & ~clr_ovf) | (push & ~do_push);
    end
  end
endmodule

// File: tb/tb_keypad_responder.sv
// tb_keypad_responder: randomized scoreboard bench for keypad_responder against a sweep-level reference model
module tb_keypad_responder;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
  logic [31:0] addr_in = 32'h0, data_in = 32'h0, data_out;
  logic [3:0] cols, rows;
  logic [15:0] pressed = 16'h0;
  int total = 0, bad = 0;
  int m_phase = 0, m_cnt = 0;
  bit m_en = 1'b1, m_ovf = 1'b0, m_live = 1'b0, m_wr_q = 1'b0;
  logic [15:0] m_last = 16'h0, m_stable = 16'h0, m_pend = 16'h0;
  logic [3:0] m_q[$];
  logic [31:0] sb[$];
  logic [31:0] spot[$];

  keypad_responder #(.SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
    .data_out(data_out), .cols(cols), .rows(rows));

  always #5 clk = ~clk;

  // physical matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    rows = 4'hF;
    for (int j = 0; j < 4; j++) if (cols[j] == 1'b0) rows = rows & ~pressed[j*4 +: 4];
  end

  function automatic logic [31:0] model_read(logic [31:0] a);
    int n;
    n = m_q.size();
    if (a[31:4] != 28'h0000F00) return 32'h0;
    case (a[3:2])
      2'd0: return n == 0 ? 32'h0 : {27'b0, 1'b1, m_q[0]};
      2'd1: return {24'b0, 5'(n), m_ovf, n == 4, n == 0};
      2'd2: return {31'b0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_cols();
    return m_en ? ~(4'b0001 << (m_phase / 4)) : 4'hF;
  endfunction

  task automatic model_edge();
    logic [31:0] a;
    logic [3:0] code;
    bit we, push, set_ovf;
    a = addr_in;
    code = 4'h0;
    push = 1'b0;
    set_ovf = 1'b0;
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0; m_en = 1'b1; m_phase = 0; m_cnt = 0;
      m_last = 16'h0; m_stable = 16'h0; m_pend = 16'h0; m_wr_q = 1'b0; m_live = 1'b1;
      sb.push_back(32'h0);
      return;
    end
    sb.push_back(model_read(a));
    we = wr_en && !m_wr_q && a[31:4] == 28'h0000F00;
    if (m_en && m_pend != 16'h0) begin
      for (int i = 15; i >= 0; i--) if (m_pend[i]) code = 4'(i);
      push = 1'b1;
      m_pend[code] = 1'b0;
    end
    if (we && a[3:2] == 2'd0 && m_q.size() > 0) m_q.delete(0);
    if (push) begin
      if (m_q.size() < 4) m_q.push_back(code);
      else set_ovf = 1'b1;
    end
    m_ovf = (m_ovf && !(we && a[3:2] == 2'd1 && data_in[0])) || set_ovf;
    if (m_en) begin
      if (m_phase == 15) begin
        m_cnt = (pressed == m_last) ? (m_cnt < 2 ? m_cnt + 1 : 2) : 1;
        m_last = pressed;
        if (m_cnt == 2) begin
          m_pend = m_pend | (pressed & ~m_stable);
          m_stable = pressed;
        end
      end
      m_phase = (m_phase + 1) % 16;
    end else begin
      m_phase = 0;
      m_cnt = 0;
      m_pend = 16'h0;
    end
    if (we && a[3:2] == 2'd2) m_en = data_in[0];
    m_wr_q = wr_en;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (m_live) begin
      total++;
      if (cols !== model_cols()) begin
        bad++;
        $display("FAIL cols t=%0t got=%b exp=%b", $time, cols, model_cols());
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard t=%0t got=%h exp=<none queued>", $time, data_out);
      end else begin
        e = sb.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL data_out t=%0t got=%h exp=%h", $time, data_out, e);
        end
      end
    end
    if (spot.size() > 0) begin
      e = spot.pop_front();
      total++;
      if (data_out !== e) begin
        bad++;
        $display("FAIL spot_read t=%0t got=%h exp=%h", $time, data_out, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, int hold = 1);
    addr_in = a;
    data_in = d;
    wr_en = 1'b1;
    tick(hold);
    wr_en = 1'b0;
    addr_in = 32'h0;
    data_in = 32'h0;
    tick();
  endtask

  task automatic rd(logic [31:0] a);
    addr_in = a;
    tick();
    addr_in = 32'h0;
  endtask

  task automatic rd_chk(logic [31:0] a, logic [31:0] exp);
    rd(a);
    spot.push_back(exp);
  endtask

  task automatic sweeps(logic [15:0] k, int n);
    int guard;
    guard = 0;
    while (m_phase != 0 && guard < 64) begin
      tick();
      guard++;
    end
    if (m_phase != 0) begin
      total++;
      bad++;
      $display("FAIL sweep_align got=phase%0d exp=phase0", m_phase);
    end
    pressed = k;
    tick(16 * n);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    rd_chk(32'h0000_F004, 32'h1);
    rd_chk(32'h0000_F000, 32'h0);
    rd_chk(32'h0000_1000, 32'h0);
    sweeps(16'h0000, 2);
    sweeps(16'h0200, 3);
    sweeps(16'h0000, 2);
    rd_chk(32'h0000_F000, 32'h19);
    wr(32'h0000_F000, 32'h0, 5);
    rd_chk(32'h0000_F004, 32'h1);
    for (int i = 0; i < 3; i++) begin
      sweeps(16'h0020, 1);
      sweeps(16'h0000, 1);
    end
    rd_chk(32'h0000_F004, 32'h1);
    sweeps(16'h0020, 2);
    sweeps(16'h0000, 2);
    rd_chk(32'h0000_F000, 32'h15);
    rd_chk(32'h0000_F004, 32'h08);
    wr(32'h0000_F000, 32'h0);
    sweeps(16'h1008, 2);
    rd_chk(32'h0000_F004, 32'h01);
    rd_chk(32'h0000_F004, 32'h08);
    rd_chk(32'h0000_F000, 32'h13);
    rd_chk(32'h0000_F004, 32'h10);
    sweeps(16'h0000, 2);
    wr(32'h0000_F000, 32'h0);
    rd_chk(32'h0000_F000, 32'h1C);
    wr(32'h0000_F000, 32'h0);
    rd_chk(32'h0000_F004, 32'h1);
    sweeps(16'h000F, 2);
    sweeps(16'h0000, 2);
    sweeps(16'h0010, 2);
    tick(2);
    rd_chk(32'h0000_F004, 32'h26);
    wr(32'h0000_F004, 32'h1);
    rd_chk(32'h0000_F004, 32'h22);
    sweeps(16'h0000, 2);
    sweeps(16'h0020, 2);
    wr(32'h0000_F000, 32'h0);
    rd_chk(32'h0000_F004, 32'h22);
    rd_chk(32'h0000_F000, 32'h11);
    sweeps(16'h0040, 0);
    tick(6);
    wr(32'h0000_F008, 32'h0);
    tick(40);
    rd_chk(32'h0000_F008, 32'h0);
    rd_chk(32'h0000_F004, 32'h22);
    wr(32'h0000_F008, 32'h1);
    rd_chk(32'h0000_F008, 32'h1);
    sweeps(16'h0040, 2);
    wr(32'h0000_F000, 32'h0);
    rd(32'h0000_F004);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rd_chk(32'h0000_F004, 32'h1);
    rd_chk(32'h0000_F008, 32'h1);
    for (int it = 0; it < 40; it++) begin
      sweeps(16'($urandom & $urandom), $urandom_range(1, 3));
      repeat ($urandom_range(1, 4)) begin
        case ($urandom_range(0, 5))
          0: wr(32'h0000_F000, $urandom, $urandom_range(1, 3));
          1: wr(32'h0000_F004, $urandom);
          2: wr(32'h0000_F008, $urandom | 32'h1);
          3: rd(32'h0000_F000 | ($urandom & 32'hF));
          4: rd($urandom);
          default: wr($urandom & 32'hFFFF_0FFF, $urandom);
        endcase
      end
    end
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
